// File: rtl/serial_alu_pkg.sv
// Shared types, opcode constants and op decode helpers for the bit-serial ALU sequencer.
package serial_alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_SUBB = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_ADC  = 3'b110;
  localparam logic [2:0] OP_BAD  = 3'b111;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;

  function automatic logic cin0(input logic [2:0] op_code, input logic stored_carry);
    logic c;
    c = 1'b0;
    case (op_code)
      OP_SUB, OP_INC: c = 1'b1;
      OP_ADC:         c = stored_carry;
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic op_valid(input logic op_mode, input logic [2:0] op_code);
    return (op_mode == MODE_LOGIC) ? (op_code <= OP_NOT) : (op_code != OP_BAD);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Requester-side bundle of the serial ALU sequencer: request, operands, completion and flags.
interface serial_alu_ctrl_if #(parameter int WIDTH = 128);
  logic             start;
  logic             op_mode;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             abort;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero_out;
  logic             err;

  modport master (
    output start, op_mode, op_code, a_in, b_in, abort,
    input  ready, done, result, carry_out, zero_out, err
  );

  modport slave (
    input  start, op_mode, op_code, a_in, b_in, abort,
    output ready, done, result, carry_out, zero_out, err
  );
endinterface

// File: rtl/serial_shreg.sv
// WIDTH-bit right-shift register, parallel load has priority over shift; serial input enters at the MSB.
module serial_shreg #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Walks a WIDTH-bit op LSB-first through one external 1-bit ALU slice; done WIDTH+1 cycles after start
// (1 for an invalid op). One op in flight: start is only taken while ready, abort cancels a running op.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_alu_ctrl_if.slave req,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_mode,
  output logic             slice_cin,
  output logic [2:0]       slice_op,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             accept, step, finish, op_ok;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, stored_q, mode_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q, zero_q, err_q;
  logic             run;
  logic             unused_bits;

  assign op_ok    = op_valid(req.op_mode, req.op_code);
  assign acc_next = {slice_out, acc_q[WIDTH-1:1]};
  assign run      = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.start) begin
          accept  = 1'b1;
          state_d = op_ok ? RUN : DONE;
        end
      end
      RUN: begin
        // abort outranks the final-bit capture
        if (req.abort) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == LAST) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      stored_q    <= 1'b0;
      mode_q      <= 1'b0;
      op_q        <= 3'b000;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        carry_q <= cin0(req.op_code, stored_q);
        mode_q  <= req.op_mode;
        op_q    <= req.op_code;
        if (!op_ok) err_q <= 1'b1;
      end
      if (step) begin
        cnt_q   <= finish ? '0 : cnt_q + 1'b1;
        carry_q <= slice_cout;
      end
      if (finish) begin
        result_q    <= acc_next;
        carry_out_q <= (mode_q == MODE_ARITH) ? slice_cout : 1'b0;
        zero_q      <= (acc_next == '0);
        err_q       <= 1'b0;
        if (mode_q == MODE_ARITH) stored_q <= slice_cout;
      end
    end
  end

  serial_shreg #(.WIDTH(WIDTH)) u_a_shreg (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_dat(req.a_in),
    .shift(step), .sin(1'b0), .q(a_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_shreg (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_dat(req.b_in),
    .shift(step), .sin(1'b0), .q(b_q)
  );

  // Accumulates slice outputs; only copied to result on the final bit so result stays stable while running.
  serial_shreg #(.WIDTH(WIDTH)) u_res_shreg (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_dat('0),
    .shift(step), .sin(slice_out), .q(acc_q)
  );

  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

  assign slice_a    = run & a_q[0];
  assign slice_b    = run & b_q[0];
  assign slice_mode = run & mode_q;
  assign slice_cin  = run & (mode_q == MODE_ARITH) & carry_q;
  assign slice_op   = run ? op_q : 3'b000;

  assign req.ready     = (state_q == IDLE);
  assign req.done      = (state_q == DONE);
  assign req.result    = result_q;
  assign req.carry_out = carry_out_q;
  assign req.zero_out  = zero_q;
  assign req.err       = err_q;

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer that time-shares a single external one-bit ALU slice across a WIDTH-bit operation. It walks operands LSB-first, feeds the slice's carry-out back into its carry-in, and assembles the result in a shift register. It reports carry, zero and error flags to the requester. It sits between the instruction/issue logic and the one-bit ALU slice, replacing a WIDTH-wide ripple array with one slice plus WIDTH cycles.

## Interface
- WIDTH, 128, operand/result width in bits (>= 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- op_mode  in  1  0 = arithmetic, 1 = logic (slice mode encoding)
- op_code  in  3  slice operation select
- a_in, b_in  in  WIDTH  operands, sampled on accept only
- abort  in  1  cancel the in-flight operation
- ready  out  1  idle, able to accept start
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  result, held until the next completion
- carry_out, zero_out, err  out  1  flags, updated with done
- slice_a, slice_b, slice_mode, slice_cin  out  1  drive to slice
- slice_op  out  3  drive to slice
- slice_out, slice_cout  in  1  slice sum/logic output, carry output (combinational)

## Operation
- Arithmetic ops (op_mode=0), initial carry: 000 ADD cin0=0; 001 SUB cin0=1; 010 INC (a+1) cin0=1; 011 SUBB (a+~b) cin0=0; 100 PASS a cin0=0; 101 DEC (a+all-ones) cin0=0; 110 ADC cin0=stored carry; 111 invalid.
- Logic ops (op_mode=1): 000 AND, 001 OR, 010 XOR, 011 NOT a; 100–111 invalid. Slice cin is driven 0 in logic mode.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start, latch a_in/b_in/op into shift registers, set bit counter=0, and set carry register=cin0.
  - Valid op -> RUN.
  - Invalid op -> DONE with err=1. result, carry_out and stored carry are unchanged.
- RUN: drive slice_a/slice_b = operand LSBs, slice_cin = carry register.
  - Each cycle: shift slice_out into result MSB (shift right), load carry register from slice_cout, shift operands right, increment counter.
  - After bit WIDTH-1 is captured -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
  - carry_out = final slice_cout (arithmetic) or 0 (logic).
  - zero_out = 1 iff all WIDTH result bits are 0.
  - err = 0 on a valid op.
  - Stored carry (used by ADC) = carry_out on a valid arithmetic op only.
- abort in RUN -> IDLE next edge. No done; result, flags and stored carry are unchanged. abort in IDLE or DONE is ignored.
- start while not ready is ignored (not queued).
- Slice drive outputs are 0 whenever the block is not in RUN.

## Timing
- Reset values:
  - state IDLE; ready=1, done=0.
  - result=0, carry_out=0, zero_out=0, err=0.
  - stored carry=0, counter=0, all slice drives 0.
- Accept at edge t. Bit i is presented to the slice during cycle t+1+i. Last bit is captured at edge t+WIDTH. done is high in the cycle after edge t+WIDTH, and ready returns one cycle after that.
- Latency start->done: WIDTH+1 cycles for a valid op, 1 cycle for an invalid op.
- Throughput: one operation per WIDTH+2 cycles.
- result and flags change only on the edge entering DONE, and are stable while done=1 and afterwards.
- Counter width: $clog2(WIDTH). Terminal count is WIDTH-1; there is no wrap-around inside RUN.
- rst_n asserted mid-RUN: immediate return to reset values. The partial result is discarded.
- Simultaneous abort with the final bit edge: abort wins, no done.

## Structure
- Package serial_alu_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - arithmetic/logic opcode localparams;
  - function cin0(op_code, stored_carry);
  - function op_valid(op_mode, op_code).
- One natural sub-module, serial_shreg: a parameterised WIDTH-bit right-shift register with parallel load and serial-in. Instantiate it three times (a, b, result).
- The one-bit slice is instantiated by the parent and connected through the slice_* ports, so the slice can be shared or replaced.

## Test plan
- ADD, a=all-ones, b=1 -> done at accept+129 cycles; result=0, carry_out=1, zero_out=1, err=0.
- ADC after that, a=5, b=3 -> result=9 (stored carry 1 used), carry_out=0, zero_out=0.
- SUB, a=b=0x1234 -> result=0, carry_out=1, zero_out=1. Then SUB a=0, b=1 -> result=all-ones, carry_out=0.
- Logic XOR, a=0xF0F0, b=0xFF00 -> result=0x0FF0, carry_out=0. A following ADC still sees the earlier stored carry.
- Invalid op: logic 101 -> done exactly 1 cycle after accept, err=1, result/carry unchanged. A start pulsed during a RUN is ignored.
- abort at bit 40 -> no done, ready next cycle, result unchanged. rst_n low at bit 70 -> all outputs at reset values asynchronously.
